// File: rtl/systolic_mm_engine.sv
// rtl/systolic_mm_engine.sv - NxN output-stationary systolic matrix-multiply engine with skewed streaming input
// Optional macro SYSTOLIC_OUT_SAT_EN saturates each output to the signed 2*WIDTH range before ReLU.
module systolic_mm_engine #(
    parameter int N         = 2,
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 2*WIDTH+4,
    parameter int KW        = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [KW-1:0]                k_len,
    input  logic                         activation,
    output logic                         busy,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N*WIDTH-1:0]           a_data,
    input  logic [N*WIDTH-1:0]           b_data,
    output logic                         c_valid,
    input  logic                         c_ready,
    output logic [N*N*ACC_WIDTH-1:0]     c_data
);
    localparam int PW = 2*WIDTH;
    localparam int DW = $clog2(2*N);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

    state_t          state;
    logic [KW-1:0]   k_len_q;
    logic [KW-1:0]   beat_cnt;
    logic [DW-1:0]   drain_cnt;
    logic            act_q;
    logic            accept;
    logic            advance;
    logic            clear;

    assign accept  = in_valid && in_ready;
    assign advance = (state == S_LOAD) || (state == S_DRAIN);
    assign clear   = (state == S_IDLE) && start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            k_len_q   <= '0;
            beat_cnt  <= '0;
            drain_cnt <= '0;
            act_q     <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
            c_valid   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        k_len_q  <= k_len;
                        act_q    <= activation;
                        beat_cnt <= '0;
                        busy     <= 1'b1;
                        if (k_len == '0) begin
                            state   <= S_DONE;
                            c_valid <= 1'b1;
                        end else begin
                            state    <= S_LOAD;
                            in_ready <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        if (beat_cnt == k_len_q - KW'(1)) begin
                            state     <= S_DRAIN;
                            in_ready  <= 1'b0;
                            drain_cnt <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + KW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    // 2N-1 flush cycles let the last beat reach PE(N-1,N-1)
                    if (drain_cnt == DW'(2*N-2)) begin
                        state   <= S_DONE;
                        c_valid <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + DW'(1);
                    end
                end
                S_DONE: begin
                    if (c_ready) begin
                        state   <= S_IDLE;
                        c_valid <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    logic signed [WIDTH-1:0] inj_a  [N];
    logic signed [WIDTH-1:0] inj_b  [N];
    logic signed [WIDTH-1:0] a_head [N];
    logic signed [WIDTH-1:0] b_head [N];

    // Cycles without an accepted beat inject zero bubbles
    always_comb begin
        for (int i = 0; i < N; i++) begin
            inj_a[i] = accept ? $signed(a_data[i*WIDTH +: WIDTH]) : '0;
            inj_b[i] = accept ? $signed(b_data[i*WIDTH +: WIDTH]) : '0;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_skew
        if (i == 0) begin : g_direct
            assign a_head[i] = inj_a[i];
            assign b_head[i] = inj_b[i];
        end else begin : g_delay
            logic signed [WIDTH-1:0] a_sk [i];
            logic signed [WIDTH-1:0] b_sk [i];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int d = 0; d < i; d++) begin
                        a_sk[d] <= '0;
                        b_sk[d] <= '0;
                    end
                end else if (clear) begin
                    for (int d = 0; d < i; d++) begin
                        a_sk[d] <= '0;
                        b_sk[d] <= '0;
                    end
                end else if (advance) begin
                    a_sk[0] <= inj_a[i];
                    b_sk[0] <= inj_b[i];
                    for (int d = 1; d < i; d++) begin
                        a_sk[d] <= a_sk[d-1];
                        b_sk[d] <= b_sk[d-1];
                    end
                end
            end

            assign a_head[i] = a_sk[i-1];
            assign b_head[i] = b_sk[i-1];
        end
    end

    // a_pipe/b_pipe[i][j] are the operands presented to PE(i,j) this cycle
    logic signed [WIDTH-1:0]     a_pipe   [N][N];
    logic signed [WIDTH-1:0]     b_pipe   [N][N];
    logic signed [ACC_WIDTH-1:0] acc      [N][N];
    logic signed [PW-1:0]        prod     [N][N];
    logic signed [ACC_WIDTH-1:0] prod_ext [N][N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                prod[i][j]     = a_pipe[i][j] * b_pipe[i][j];
                prod_ext[i][j] = {{(ACC_WIDTH-PW){prod[i][j][PW-1]}}, prod[i][j]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_pipe[i][j] <= '0;
                    b_pipe[i][j] <= '0;
                    acc[i][j]    <= '0;
                end
            end
        end else if (clear) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_pipe[i][j] <= '0;
                    b_pipe[i][j] <= '0;
                    acc[i][j]    <= '0;
                end
            end
        end else if (advance) begin
            for (int i = 0; i < N; i++) begin
                a_pipe[i][0] <= a_head[i];
                b_pipe[0][i] <= b_head[i];
                for (int j = 1; j < N; j++) begin
                    a_pipe[i][j] <= a_pipe[i][j-1];
                    b_pipe[j][i] <= b_pipe[j-1][i];
                end
            end
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    acc[i][j] <= acc[i][j] + prod_ext[i][j];
                end
            end
        end
    end

`ifdef SYSTOLIC_OUT_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = {{(ACC_WIDTH-PW+1){1'b0}}, {(PW-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = {{(ACC_WIDTH-PW+1){1'b1}}, {(PW-1){1'b0}}};
`endif

    logic signed [ACC_WIDTH-1:0] out_v;

    always_comb begin
        c_data = '0;
        out_v  = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                out_v = acc[i][j];
`ifdef SYSTOLIC_OUT_SAT_EN
                if (out_v > SAT_MAX) begin
                    out_v = SAT_MAX;
                end else if (out_v < SAT_MIN) begin
                    out_v = SAT_MIN;
                end
`endif
                if (act_q && out_v[ACC_WIDTH-1]) begin
                    out_v = '0;
                end
                c_data[(i*N+j)*ACC_WIDTH +: ACC_WIDTH] = out_v;
            end
        end
    end

endmodule

// File: tb/tb_systolic_mm_engine.sv
// tb/tb_systolic_mm_engine.sv - scoreboard bench for systolic_mm_engine (N=2, WIDTH=8)
module tb_systolic_mm_engine;
    localparam int N   = 2;
    localparam int W   = 8;
    localparam int AW  = 2*W+4;
    localparam int KW  = 8;
    localparam int CW  = N*N*AW;
`ifdef SYSTOLIC_OUT_SAT_EN
    localparam int BIG = 32767;
`else
    localparam int BIG = 48387;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [KW-1:0] k_len;
    logic          activation;
    logic          busy;
    logic          in_valid;
    logic          in_ready;
    logic [N*W-1:0] a_data;
    logic [N*W-1:0] b_data;
    logic          c_valid;
    logic          c_ready;
    logic [CW-1:0] c_data;

    systolic_mm_engine #(.N(N), .WIDTH(W), .ACC_WIDTH(AW), .KW(KW)) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .activation(activation),
        .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .a_data(a_data),
        .b_data(b_data), .c_valid(c_valid), .c_ready(c_ready), .c_data(c_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [CW-1:0] c;
        bit            kzero;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   a_m [2][3];
    int   b_m [3][2];
    int   last_acc = 0;
    int   start_cyc = 0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic logic [CW-1:0] pack4(input int c00, input int c01, input int c10, input int c11);
        logic [AW-1:0] e0, e1, e2, e3;
        e0 = AW'(c00);
        e1 = AW'(c01);
        e2 = AW'(c10);
        e3 = AW'(c11);
        return {e3, e2, e1, e0};
    endfunction

    task automatic set_ab(input int a00, input int a01, input int a10, input int a11,
                          input int b00, input int b01, input int b10, input int b11);
        a_m[0][0] = a00; a_m[0][1] = a01; a_m[1][0] = a10; a_m[1][1] = a11;
        b_m[0][0] = b00; b_m[0][1] = b01; b_m[1][0] = b10; b_m[1][1] = b11;
    endtask

    // Monitor: pops the scoreboard on each rising c_valid
    initial begin : monitor
        logic prev_cv;
        exp_t e;
        int   want;
        prev_cv = 1'b0;
        forever begin
            @(negedge clk);
            if (in_valid && in_ready) last_acc = cyc;
            if (start && !busy) start_cyc = cyc;
            if (c_valid && !prev_cv) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got c_valid=1 expected no result pending");
                end else begin
                    e = sb_q.pop_front();
                    for (int k = 0; k < N*N; k++) begin
                        chk($sformatf("c_elem%0d", k), int'($signed(c_data[k*AW +: AW])),
                            int'($signed(e.c[k*AW +: AW])));
                    end
                    want = e.kzero ? start_cyc + 1 : last_acc + 2*N;
                    chk("c_valid_latency_cycle", cyc, want);
                end
            end
            prev_cv = c_valid;
        end
    end

    task automatic run_op(input int k, input logic act, input logic [7:0] pat,
                          input bit junk, input logic [CW-1:0] exp_c);
        int  idx;
        int  t;
        bit  acc_now;
        sb_q.push_back('{c: exp_c, kzero: (k == 0)});
        @(posedge clk); #1;
        start = 1'b1; k_len = KW'(k); activation = act;
        @(posedge clk); #1;
        start = 1'b0;
        idx = 0;
        t = 0;
        while (idx < k && t < 64) begin
            in_valid = (t < 8) ? pat[t] : 1'b1;
            a_data = {a_m[1][idx][W-1:0], a_m[0][idx][W-1:0]};
            b_data = {b_m[idx][1][W-1:0], b_m[idx][0][W-1:0]};
            @(negedge clk);
            acc_now = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc_now) idx++;
            t++;
        end
        chk("beats_accepted", idx, k);
        in_valid = junk;
        a_data = junk ? {8'sd99, 8'sd99} : '0;
        b_data = junk ? {8'sd99, 8'sd99} : '0;
        t = 0;
        @(negedge clk);
        while (!c_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("c_valid_seen", int'(c_valid), 1);
        in_valid = 1'b0;
        c_ready = 1'b1;
        @(posedge clk); #1;
        c_ready = 1'b0;
        chk("busy_after_done", int'(busy), 0);
        chk("c_valid_after_done", int'(c_valid), 0);
    endtask

    initial begin : stim
        rst = 1'b1; start = 1'b0; k_len = '0; activation = 1'b0;
        in_valid = 1'b0; c_ready = 1'b0; a_data = '0; b_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_in_ready", int'(in_ready), 0);
        chk("reset_c_valid", int'(c_valid), 0);
        chk("reset_c_data_zero", int'(c_data == '0), 1);
        rst = 1'b0;

        // Basic 2x2, back-to-back beats
        set_ab(1, 2, 3, 4, 5, 6, 7, 8);
        run_op(2, 1'b0, 8'hFF, 1'b0, pack4(19, 22, 43, 50));

        // Mixed signs with and without ReLU
        set_ab(-1, 2, 3, -4, 5, 6, 7, 8);
        run_op(2, 1'b1, 8'hFF, 1'b0, pack4(9, 10, 0, 0));
        run_op(2, 1'b0, 8'hFF, 1'b0, pack4(9, 10, -13, -14));

        // Bubbles 1,0,0,1 and junk in_valid after the last beat
        set_ab(1, 2, 3, 4, 5, 6, 7, 8);
        run_op(2, 1'b0, 8'b1111_1001, 1'b1, pack4(19, 22, 43, 50));

        // k_len == 0 with held result and ignored start
        sb_q.push_back('{c: '0, kzero: 1'b1});
        @(posedge clk); #1;
        start = 1'b1; k_len = '0; activation = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            start = (i >= 1);
            in_valid = 1'b1;
            a_data = {8'sd7, 8'sd7};
            b_data = {8'sd7, 8'sd7};
            @(posedge clk); #1;
            chk($sformatf("hold_c_valid_%0d", i), int'(c_valid), 1);
            chk($sformatf("hold_busy_%0d", i), int'(busy), 1);
            chk($sformatf("hold_in_ready_%0d", i), int'(in_ready), 0);
            chk($sformatf("hold_c_data_%0d", i), int'(c_data == '0), 1);
        end
        @(negedge clk);
        c_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; c_ready = 1'b0; in_valid = 1'b0;
        a_data = '0; b_data = '0;
        chk("exit_start_ignored_busy", int'(busy), 0);
        chk("exit_c_valid", int'(c_valid), 0);

        // Asynchronous reset in LOAD after one beat
        set_ab(1, 2, 3, 4, 5, 6, 7, 8);
        @(posedge clk); #1;
        start = 1'b1; k_len = 8'd2; activation = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1;
        a_data = {8'sd3, 8'sd1};
        b_data = {8'sd6, 8'sd5};
        @(posedge clk); #1;
        in_valid = 1'b0;
        a_data = '0; b_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("pre_reset_busy", int'(busy), 1);
        chk("pre_reset_acc00", int'($signed(c_data[0 +: AW])), 5);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_in_ready", int'(in_ready), 0);
        chk("async_rst_c_valid", int'(c_valid), 0);
        chk("async_rst_c_data", int'(c_data == '0), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        run_op(2, 1'b0, 8'hFF, 1'b0, pack4(19, 22, 43, 50));

        // k_len = 3, all operands 127
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 3; k++) begin
                a_m[i][k] = 127;
                b_m[k][i] = 127;
            end
        end
        run_op(3, 1'b0, 8'hFF, 1'b0, pack4(BIG, BIG, BIG, BIG));

        repeat (4) @(posedge clk);
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
